hpu_ctrl_regs: RTL
==================

Name: hpu_ctrl_regs

Overview:
- AXI4-Lite slave register block for the HPU.
- Replaces the inline control logic and the hard-wired n-gram, window and item-count constants with runtime-programmable, parametrised registers.
- Drives the matw/run/last control levels into the stream datapath (src_ctrl, exe_ctrl, cores).
- Auto-terminates item-memory loading and reports execution status back to the host.

Parameters:
- ADDR_W, 12, AXI-Lite address bits decoded (register page = bits [ADDR_W-1:10] == 0)
- NGRAM_W, 20, width of the n-gram (addr_j) and window (addr_i) registers
- ITEM_W, 16, width of the item-memory count register and load counter
- NGRAM_DEF, 2, reset value of the NGRAM register
- WINDOW_DEF, 7, reset value of the WINDOW register
- ITEM_DEF, 99, reset value of the ITEM_NUM register
- VERSION, 32'h0001_0000, constant returned by the VERSION register

Ports:
- clk  in  1  single clock for AXI-Lite and control
- rst  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_W  write address
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1 / 1  write address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1 / 1  write data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1 / 1  write response handshake
- S_AXI_ARADDR  in  ADDR_W  read address
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1 / 1  read address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1 / 1  read data handshake
- mat_we  in  1  one item-memory word is written this cycle
- exe_busy  in  1  datapath is computing (level)
- exe_done  in  1  one-cycle pulse at the last out_fin of a run
- matw, run, last  out  1 each  control levels
- addr_j, addr_i  out  NGRAM_W each  n-gram and window registers
- item_num  out  ITEM_W  item-memory count
- control  out  32  scratch register

Behaviour:
- Reset (async, rst=1): FSM = INI; matw=run=last=0; done=0; load counter=0; addr_j=NGRAM_DEF; addr_i=WINDOW_DEF; item_num=ITEM_DEF; control=0; S_AXI_RDATA=0; BRESP/RRESP=00.
- FSM states and transitions:
  - INI: AW&W → AWW; AW only → AW; W only → W; AR only → AR1. Write has priority over read.
  - AW → AWW on WVALID.
  - W → AWW on AWVALID.
  - AWW → INI on BREADY.
  - AR1 → AR2 unconditionally.
  - AR2 → INI on RREADY.
- Ready/valid decode: AWREADY = INI|W; WREADY = INI|AW; ARREADY = INI; BVALID = AWW; RVALID = AR2.
- Write commit happens exactly once, on the edge entering AWW. BRESP is latched at the same edge. Holding BREADY low never re-commits.
- Register map (byte offsets):
  - 0x00 CTRL RW: [0] matw, [1] run, [2] last.
  - 0x04 STATUS: [0] exe_busy (RO); [1] done (sticky, W1C).
  - 0x08 NGRAM RW.
  - 0x0C WINDOW RW.
  - 0x10 CONTROL RW.
  - 0x14 ITEM_NUM RW.
  - 0x18 VERSION RO.
- WSTRB applies per byte to RW registers. Register bits above the field width are ignored on write and read back as 0.
- Writes to RO fields are ignored with BRESP=00.
- Unmapped offsets, or page bits non-zero:
  - Write: no effect, BRESP=10 (SLVERR).
  - Read: RDATA=0, RRESP=10.
- Read path: RDATA and RRESP are registered at the AR1→AR2 edge and held stable through AR2. Read latency is 2 cycles from the AR handshake to RVALID.
- Load counter:
  - Held at 0 while matw=0.
  - Increments on mat_we while matw=1.
  - When matw & mat_we & cnt==item_num, matw clears on the next edge. This gives item_num+1 loaded words; item_num=0 yields one word.
- Counter wrap at 2^ITEM_W cannot occur, because auto-clear fires first.
- A host CTRL write committing on the same edge as an auto-clear wins.
- done is set by exe_done. Set beats a simultaneous W1C.
- run is not auto-cleared; the host writes 0, and downstream blocks use ~run as their reset.
- Async reset mid-transaction aborts it: no BVALID/RVALID is issued and all registers take their defaults.

Optional Feature:
- HPU_CTRL_IRQ_EN defined:
  - Adds output port irq (1 bit, reset 0) and register 0x1C IRQ_EN RW with bit [0] = enable.
  - irq = done & enable, registered, so it rises 1 cycle after done is set and falls 1 cycle after W1C or disable.
- Undefined: no irq port; 0x1C is unmapped (SLVERR).

Decomposition:
- Package hpu_pkg holds:
  - Register offset localparams (CTRL_OFS … IRQ_EN_OFS).
  - CTRL bit indices.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - AXI-Lite FSM state encodings (INI, AW, W, AWW, AR1, AR2).
- One natural sub-module, axil_slave_fsm:
  - Contains the handshake FSM.
  - Outputs wr_commit, wr_addr, wr_data, wr_strb, rd_req, rd_addr.
  - Accepts rd_data and rd_err.
- The register file stays in hpu_ctrl_regs.

Test Plan:
- Reset → read 0x08/0x0C/0x14/0x18 → 2, 7, 99, 32'h0001_0000, RRESP=00; outputs match.
- AW 2 cycles before W, BREADY held low 3 cycles, write 0x10=32'hDEADBEEF with WSTRB=4'b0101 → control=32'h00AD00EF, one commit, BVALID held until BREADY.
- ITEM_NUM=3, CTRL=1, 4 mat_we pulses → matw falls on the edge after the 4th pulse; a 5th pulse has no effect; counter returns to 0.
- exe_done pulse → STATUS=2; write 0x04=2 in the same cycle as a second exe_done → done stays 1; a later lone W1C → STATUS=0.
- Write 0x40 and read 0x800 → BRESP=10, RRESP=10, RDATA=0, no register changes.
- HPU_CTRL_IRQ_EN: IRQ_EN=1, exe_done → irq=1 one cycle after done; W1C → irq=0 one cycle later. Macro off → 0x1C read gives SLVERR.

Source files
------------

// File: rtl/hpu_pkg.sv
// rtl/hpu_pkg.sv - shared constants, state encodings and helpers for the HPU control registers
// Contents: register byte offsets (within the 1 KiB register page), CTRL/STATUS bit
// indices, AXI response codes, AXI-Lite slave FSM state type, byte-strobe merge helper.
package hpu_pkg;

  localparam logic [9:0] CTRL_OFS     = 10'h000;
  localparam logic [9:0] STATUS_OFS   = 10'h004;
  localparam logic [9:0] NGRAM_OFS    = 10'h008;
  localparam logic [9:0] WINDOW_OFS   = 10'h00C;
  localparam logic [9:0] CONTROL_OFS  = 10'h010;
  localparam logic [9:0] ITEM_NUM_OFS = 10'h014;
  localparam logic [9:0] VERSION_OFS  = 10'h018;
  localparam logic [9:0] IRQ_EN_OFS   = 10'h01C;

  localparam int CTRL_MATW   = 0;
  localparam int CTRL_RUN    = 1;
  localparam int CTRL_LAST   = 2;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_INI = 3'd0,
    ST_AW  = 3'd1,
    ST_W   = 3'd2,
    ST_AWW = 3'd3,
    ST_AR1 = 3'd4,
    ST_AR2 = 3'd5
  } axil_state_t;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/axil_slave_fsm.sv
// rtl/axil_slave_fsm.sv - AXI4-Lite slave handshake FSM for the HPU register block
// Ports: clk, rst (async, active-high); AXI-Lite AW/W/B/AR/R channel signals;
// wr_commit/wr_addr/wr_data/wr_strb (one-cycle write strobe to the register file, with
// wr_err returned for BRESP); rd_req/rd_addr (read lookup during AR1, with rd_data/rd_err).
module axil_slave_fsm
  import hpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              wr_commit,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  axil_state_t       state;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [ADDR_W-1:0] ar_addr_q;

  assign awready = (state == ST_INI) || (state == ST_W);
  assign wready  = (state == ST_INI) || (state == ST_AW);
  assign arready = (state == ST_INI);
  assign bvalid  = (state == ST_AWW);
  assign rvalid  = (state == ST_AR2);

  // Commit fires only on the transition into AWW, so a stalled BREADY cannot re-write.
  assign wr_commit = ((state == ST_INI) && awvalid && wvalid) ||
                     ((state == ST_AW)  && wvalid) ||
                     ((state == ST_W)   && awvalid);

  // Whichever half arrived first comes from its capture register, the other is live.
  assign wr_addr = (state == ST_AW) ? aw_addr_q : awaddr;
  assign wr_data = (state == ST_W)  ? w_data_q  : wdata;
  assign wr_strb = (state == ST_W)  ? w_strb_q  : wstrb;

  assign rd_req  = (state == ST_AR1);
  assign rd_addr = ar_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INI;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      bresp     <= RESP_OKAY;
    end else begin
      if (wr_commit) bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      case (state)
        ST_INI: begin
          if (awvalid && wvalid) begin
            state <= ST_AWW;
          end else if (awvalid) begin
            aw_addr_q <= awaddr;
            state     <= ST_AW;
          end else if (wvalid) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            state    <= ST_W;
          end else if (arvalid) begin
            ar_addr_q <= araddr;
            state     <= ST_AR1;
          end
        end
        ST_AW:  if (wvalid)  state <= ST_AWW;
        ST_W:   if (awvalid) state <= ST_AWW;
        ST_AWW: if (bready)  state <= ST_INI;
        ST_AR1: begin
          rdata <= rd_data;
          rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
          state <= ST_AR2;
        end
        ST_AR2: if (rready)  state <= ST_INI;
        default: state <= ST_INI;
      endcase
    end
  end

endmodule

// File: rtl/hpu_ctrl_regs.sv
// rtl/hpu_ctrl_regs.sv - HPU AXI4-Lite control/status register block
// Ports: clk, rst (async, active-high); S_AXI_* AXI4-Lite slave; mat_we/exe_busy/exe_done
// from the datapath; matw/run/last control levels; addr_j (n-gram), addr_i (window),
// item_num, control (scratch). Optional macro HPU_CTRL_IRQ_EN adds irq output and IRQ_EN reg.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int          NGRAM_W    = 20,
  parameter int          ITEM_W     = 16,
  parameter int          NGRAM_DEF  = 2,
  parameter int          WINDOW_DEF = 7,
  parameter int          ITEM_DEF   = 99,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic [3:0]         S_AXI_WSTRB,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [ADDR_W-1:0]  S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  input  logic               mat_we,
  input  logic               exe_busy,
  input  logic               exe_done,
  output logic               matw,
  output logic               run,
  output logic               last,
  output logic [NGRAM_W-1:0] addr_j,
  output logic [NGRAM_W-1:0] addr_i,
  output logic [ITEM_W-1:0]  item_num,
  output logic [31:0]        control
`ifdef HPU_CTRL_IRQ_EN
  ,
  output logic               irq
`endif
);

  logic              wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_err;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_err;

  logic              done;
  logic [ITEM_W-1:0] load_cnt;
`ifdef HPU_CTRL_IRQ_EN
  logic              irq_en;
`endif

  axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .awaddr    (S_AXI_AWADDR),
    .awvalid   (S_AXI_AWVALID),
    .awready   (S_AXI_AWREADY),
    .wdata     (S_AXI_WDATA),
    .wstrb     (S_AXI_WSTRB),
    .wvalid    (S_AXI_WVALID),
    .wready    (S_AXI_WREADY),
    .bresp     (S_AXI_BRESP),
    .bvalid    (S_AXI_BVALID),
    .bready    (S_AXI_BREADY),
    .araddr    (S_AXI_ARADDR),
    .arvalid   (S_AXI_ARVALID),
    .arready   (S_AXI_ARREADY),
    .rdata     (S_AXI_RDATA),
    .rresp     (S_AXI_RRESP),
    .rvalid    (S_AXI_RVALID),
    .rready    (S_AXI_RREADY),
    .wr_commit (wr_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_err    (wr_err),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_err    (rd_err)
  );

  function automatic logic ofs_mapped(input logic [9:0] ofs);
    logic hit;
    hit = (ofs == CTRL_OFS)    || (ofs == STATUS_OFS)   || (ofs == NGRAM_OFS) ||
          (ofs == WINDOW_OFS)  || (ofs == CONTROL_OFS)  || (ofs == ITEM_NUM_OFS) ||
          (ofs == VERSION_OFS);
`ifdef HPU_CTRL_IRQ_EN
    hit = hit || (ofs == IRQ_EN_OFS);
`endif
    return hit;
  endfunction

  // Write decode: addresses outside page 0 alias nothing.
  logic       wr_ok;
  logic       we_ctrl, w1c_done, we_ngram, we_window, we_control, we_item;
  logic [9:0] wr_ofs;

  assign wr_ofs     = wr_addr[9:0];
  assign wr_ok      = (wr_addr[ADDR_W-1:10] == '0) && ofs_mapped(wr_ofs);
  assign wr_err     = !wr_ok;
  assign we_ctrl    = wr_commit && wr_ok && (wr_ofs == CTRL_OFS) && wr_strb[0];
  assign w1c_done   = wr_commit && wr_ok && (wr_ofs == STATUS_OFS) && wr_strb[0] &&
                      wr_data[STATUS_DONE];
  assign we_ngram   = wr_commit && wr_ok && (wr_ofs == NGRAM_OFS);
  assign we_window  = wr_commit && wr_ok && (wr_ofs == WINDOW_OFS);
  assign we_control = wr_commit && wr_ok && (wr_ofs == CONTROL_OFS);
  assign we_item    = wr_commit && wr_ok && (wr_ofs == ITEM_NUM_OFS);

  // Last expected item-memory word: drop matw so loading stops by itself.
  logic auto_clr;
  assign auto_clr = matw && mat_we && (load_cnt == item_num);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matw     <= 1'b0;
      run      <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      load_cnt <= '0;
      addr_j   <= NGRAM_W'(NGRAM_DEF);
      addr_i   <= NGRAM_W'(WINDOW_DEF);
      item_num <= ITEM_W'(ITEM_DEF);
      control  <= '0;
    end else begin
      // A host CTRL write on the same edge as auto-clear takes precedence.
      if (we_ctrl) begin
        matw <= wr_data[CTRL_MATW];
        run  <= wr_data[CTRL_RUN];
        last <= wr_data[CTRL_LAST];
      end else if (auto_clr) begin
        matw <= 1'b0;
      end

      if (!matw || auto_clr) load_cnt <= '0;
      else if (mat_we)       load_cnt <= load_cnt + ITEM_W'(1);

      // A new completion beats a simultaneous write-1-to-clear.
      if (exe_done)      done <= 1'b1;
      else if (w1c_done) done <= 1'b0;

      if (we_ngram)   addr_j   <= NGRAM_W'(strb_merge(32'(addr_j), wr_data, wr_strb));
      if (we_window)  addr_i   <= NGRAM_W'(strb_merge(32'(addr_i), wr_data, wr_strb));
      if (we_control) control  <= strb_merge(control, wr_data, wr_strb);
      if (we_item)    item_num <= ITEM_W'(strb_merge(32'(item_num), wr_data, wr_strb));
    end
  end

`ifdef HPU_CTRL_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_commit && wr_ok && (wr_ofs == IRQ_EN_OFS) && wr_strb[0]) irq_en <= wr_data[0];
      irq <= done && irq_en;
    end
  end
`endif

  // Read lookup, sampled by the FSM during AR1.
  logic [9:0] rd_ofs;
  assign rd_ofs = rd_addr[9:0];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_req) begin
      if (rd_addr[ADDR_W-1:10] != '0) begin
        rd_err = 1'b1;
      end else begin
        case (rd_ofs)
          CTRL_OFS:     rd_data = {29'b0, last, run, matw};
          STATUS_OFS:   rd_data = {30'b0, done, exe_busy};
          NGRAM_OFS:    rd_data = 32'(addr_j);
          WINDOW_OFS:   rd_data = 32'(addr_i);
          CONTROL_OFS:  rd_data = control;
          ITEM_NUM_OFS: rd_data = 32'(item_num);
          VERSION_OFS:  rd_data = VERSION;
`ifdef HPU_CTRL_IRQ_EN
          IRQ_EN_OFS:   rd_data = {31'b0, irq_en};
`endif
          default:      rd_err  = 1'b1;
        endcase
      end
    end
  end

endmodule
